// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Definitions shared by the byte-stack sequencer and its neighbours:
//   STACK_CAP : default stack capacity in bytes
//   op_e      : word operation select (push / pop)
//   state_e   : sequencer FSM states
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int STACK_CAP = 256;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_HI  = 3'd1,
        ST_PUSH_LO  = 3'd2,
        ST_POP_LO   = 3'd3,
        ST_POP_HI   = 3'd4,
        ST_POP_WAIT = 3'd5,
        ST_ACK      = 3'd6
    } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
// Arbitrates 16-bit word push/pop requests from the execution unit (E) and the
// interrupt unit (I) and sequences each word as two byte operations on an
// external 8-bit stack. Tracks stack depth and rejects operations that would
// overflow or underflow; a rejected operation produces no stack activity.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   e_req/e_pop/e_wdata/e_ack     execution-unit request handshake
//   i_req/i_pop/i_wdata/i_ack     interrupt-unit request handshake (priority)
//   rdata                         last popped word, held until the next pop
//   err                           qualifies an ack: operation was rejected
//   busy                          FSM is not in IDLE
//   depth                         bytes currently on the stack (0..CAP)
//   stk_push/stk_pop/stk_in       strobes and data towards the byte stack
//   stk_out                       byte stack output (updates on the pop edge)
// -----------------------------------------------------------------------------
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int CAP = STACK_CAP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        e_req,
    input  logic        e_pop,
    input  logic [15:0] e_wdata,
    output logic        e_ack,
    input  logic        i_req,
    input  logic        i_pop,
    input  logic [15:0] i_wdata,
    output logic        i_ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic [8:0]  depth,
    output logic        stk_push,
    output logic        stk_pop,
    output logic [7:0]  stk_in,
    input  logic [7:0]  stk_out
);

    localparam logic [8:0] PUSH_MAX = 9'(CAP - 2);
    localparam logic [8:0] POP_MIN  = 9'd2;

    state_e      state_q, state_d;
    logic        gnt_i_q, gnt_i_d;     // 1: interrupt unit owns the current op
    op_e         op_q,    op_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q,   err_d;
    logic [15:0] rdata_q, rdata_d;
    logic [8:0]  depth_q, depth_d;

    // Fixed-priority pick: I wins whenever both request in the same cycle.
    op_e         req_op;
    logic [15:0] req_wdata;
    logic        req_legal;

    assign req_op    = i_req ? op_e'(i_pop) : op_e'(e_pop);
    assign req_wdata = i_req ? i_wdata : e_wdata;
    assign req_legal = (req_op == OP_PUSH) ? (depth_q <= PUSH_MAX)
                                           : (depth_q >= POP_MIN);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        gnt_i_d = gnt_i_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        depth_d = depth_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req || e_req) begin
                    gnt_i_d = i_req;
                    op_d    = req_op;
                    wdata_d = req_wdata;
                    err_d   = !req_legal;
                    if (!req_legal)
                        state_d = ST_ACK;
                    else if (req_op == OP_PUSH)
                        state_d = ST_PUSH_HI;
                    else
                        state_d = ST_POP_LO;
                end
            end
            ST_PUSH_HI: state_d = ST_PUSH_LO;
            ST_PUSH_LO: state_d = ST_ACK;
            ST_POP_LO:  state_d = ST_POP_HI;
            ST_POP_HI: begin
                // stk_out now shows the low byte popped at the previous edge.
                rdata_d[7:0] = stk_out;
                state_d      = ST_POP_WAIT;
            end
            ST_POP_WAIT: begin
                rdata_d[15:8] = stk_out;
                state_d       = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The legality check in IDLE guarantees this never wraps.
        if (stk_push)
            depth_d = depth_q + 9'd1;
        else if (stk_pop)
            depth_d = depth_q - 9'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_i_q <= 1'b0;
            op_q    <= OP_PUSH;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_i_q <= gnt_i_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            depth_q <= depth_d;
        end
    end

    // Outputs decode from registered state only; no input reaches an output
    // combinationally.
    assign busy     = (state_q != ST_IDLE);
    assign stk_push = (state_q == ST_PUSH_HI) || (state_q == ST_PUSH_LO);
    assign stk_pop  = (state_q == ST_POP_LO)  || (state_q == ST_POP_HI);
    assign stk_in   = (state_q == ST_PUSH_HI) ? wdata_q[15:8] :
                      (state_q == ST_PUSH_LO) ? wdata_q[7:0]  : 8'h00;
    assign e_ack    = (state_q == ST_ACK) && !gnt_i_q;
    assign i_ack    = (state_q == ST_ACK) &&  gnt_i_q;
    assign err      = (state_q == ST_ACK) &&  err_q;
    assign rdata    = rdata_q;
    assign depth    = depth_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_ctrl
// Self-checking bench for stack_ctrl. A behavioural byte stack sits beside the
// DUT on the same reset. Single word operations come from a vector table;
// arbitration, overflow and reset-mid-pop are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_stack_ctrl;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        e_req, e_pop, i_req, i_pop;
    logic [15:0] e_wdata, i_wdata;
    logic        e_ack, i_ack, err, busy;
    logic [15:0] rdata;
    logic [8:0]  depth;
    logic        stk_push, stk_pop;
    logic [7:0]  stk_in, stk_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.CAP(STACK_CAP)) dut (
        .clk(clk), .rst(rst),
        .e_req(e_req), .e_pop(e_pop), .e_wdata(e_wdata), .e_ack(e_ack),
        .i_req(i_req), .i_pop(i_pop), .i_wdata(i_wdata), .i_ack(i_ack),
        .rdata(rdata), .err(err), .busy(busy), .depth(depth),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_in(stk_in),
        .stk_out(stk_out)
    );

    // Behavioural byte stack: Out updates on the same edge that samples pop.
    logic [7:0] mem [0:255];
    logic [8:0] sp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp      <= '0;
            stk_out <= '0;
        end else if (stk_push) begin
            mem[sp[7:0]] <= stk_in;
            sp           <= sp + 9'd1;
        end else if (stk_pop) begin
            stk_out <= mem[8'(sp - 9'd1)];
            sp      <= sp - 9'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one word operation starting just after a rising edge with the FSM
    // in IDLE; cycle 0 is the cycle whose closing edge samples the request.
    task automatic do_op(input string name, input logic use_i, input logic pop,
                         input logic [15:0] wd, input logic exp_err,
                         input logic [15:0] exp_rd, input logic [8:0] exp_depth);
        int          ack_cyc = -1;
        logic [31:0] push_mask = '0;
        logic [31:0] pop_mask  = '0;
        logic [15:0] pushed    = '0;
        logic        got_err   = 1'b0;
        logic        busy1     = 1'b0;
        int          wrong     = 0;
        int          exp_ack;
        logic [31:0] exp_pm, exp_qm;

        if (use_i) begin i_req = 1'b1; i_pop = pop; i_wdata = wd; end
        else       begin e_req = 1'b1; e_pop = pop; e_wdata = wd; end

        for (int n = 0; n < 20 && ack_cyc < 0; n++) begin
            @(negedge clk);
            if (stk_push) begin
                push_mask[n] = 1'b1;
                if (n == 1) pushed[15:8] = stk_in;
                if (n == 2) pushed[7:0]  = stk_in;
            end
            if (stk_pop) pop_mask[n] = 1'b1;
            if (n == 1) busy1 = busy;
            if (use_i ? e_ack : i_ack) wrong++;
            if (use_i ? i_ack : e_ack) begin
                ack_cyc = n;
                got_err = err;
            end
            @(posedge clk);
            #1;
        end
        if (use_i) i_req = 1'b0; else e_req = 1'b0;

        exp_ack = exp_err ? 1 : (pop ? 4 : 3);
        exp_pm  = (!exp_err && !pop) ? 32'h6 : 32'h0;
        exp_qm  = (!exp_err &&  pop) ? 32'h6 : 32'h0;

        check({name, " ack_cycle"}, ack_cyc, exp_ack);
        check({name, " err"},       {31'd0, got_err}, {31'd0, exp_err});
        check({name, " push_strobes"}, push_mask, exp_pm);
        check({name, " pop_strobes"},  pop_mask,  exp_qm);
        check({name, " other_ack"}, wrong, 0);
        check({name, " busy"},      {31'd0, busy1}, 32'd1);
        if (!exp_err && !pop) check({name, " stk_in"}, {16'd0, pushed}, {16'd0, wd});
        check({name, " rdata"},     {16'd0, rdata}, {16'd0, exp_rd});
        check({name, " depth"},     {23'd0, depth}, {23'd0, exp_depth});
    endtask

    typedef struct {
        string       name;
        logic        use_i;
        logic        pop;
        logic [15:0] wd;
        logic        exp_err;
        logic [15:0] exp_rd;
        logic [8:0]  exp_depth;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          i_ack_cyc, e_ack_cyc;
        logic [31:0] outs;
        int          late_ack;

        vecs[0] = '{"e_push_1234",   1'b0, 1'b0, 16'h1234, 1'b0, 16'h0000, 9'd2};
        vecs[1] = '{"e_pop_1234",    1'b0, 1'b1, 16'h0000, 1'b0, 16'h1234, 9'd0};
        vecs[2] = '{"e_underflow",   1'b0, 1'b1, 16'h0000, 1'b1, 16'h1234, 9'd0};
        vecs[3] = '{"i_push_abcd",   1'b1, 1'b0, 16'hABCD, 1'b0, 16'h1234, 9'd2};
        vecs[4] = '{"i_push_5678",   1'b1, 1'b0, 16'h5678, 1'b0, 16'h1234, 9'd4};
        vecs[5] = '{"e_pop_5678",    1'b0, 1'b1, 16'h0000, 1'b0, 16'h5678, 9'd2};
        vecs[6] = '{"i_pop_abcd",    1'b1, 1'b1, 16'h0000, 1'b0, 16'hABCD, 9'd0};
        vecs[7] = '{"i_underflow",   1'b1, 1'b1, 16'h0000, 1'b1, 16'hABCD, 9'd0};

        rst = 1'b1;
        e_req = 1'b0; e_pop = 1'b0; e_wdata = '0;
        i_req = 1'b0; i_pop = 1'b0; i_wdata = '0;
        #1;
        outs = {e_ack, i_ack, err, busy, stk_push, stk_pop, stk_in, 18'd0};
        check("reset_ctrl_outs", outs, 32'd0);
        check("reset_rdata", {16'd0, rdata}, 32'd0);
        check("reset_depth", {23'd0, depth}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[k])
            do_op(vecs[k].name, vecs[k].use_i, vecs[k].pop, vecs[k].wd,
                  vecs[k].exp_err, vecs[k].exp_rd, vecs[k].exp_depth);

        // Simultaneous pushes: I served first, E waits through one IDLE cycle.
        i_req = 1'b1; i_pop = 1'b0; i_wdata = 16'hBEEF;
        e_req = 1'b1; e_pop = 1'b0; e_wdata = 16'h1111;
        i_ack_cyc = -1; e_ack_cyc = -1;
        for (int n = 0; n < 30 && e_ack_cyc < 0; n++) begin
            @(negedge clk);
            if (i_ack) i_ack_cyc = n;
            if (e_ack) e_ack_cyc = n;
            @(posedge clk); #1;
            if (i_ack_cyc >= 0) i_req = 1'b0;
        end
        e_req = 1'b0;
        check("sim_i_ack_cycle", i_ack_cyc, 3);
        check("sim_e_ack_cycle", e_ack_cyc, 7);
        check("sim_depth", {23'd0, depth}, 32'd4);
        do_op("sim_pop_1111", 1'b0, 1'b1, 16'h0, 1'b0, 16'h1111, 9'd2);
        do_op("sim_pop_beef", 1'b0, 1'b1, 16'h0, 1'b0, 16'hBEEF, 9'd0);

        // Fill to capacity, then one more push must be rejected.
        for (int k = 0; k < 128; k++)
            do_op("fill_push", 1'b0, 1'b0, {8'(k), ~8'(k)}, 1'b0, 16'hBEEF, 9'(2 * (k + 1)));
        check("full_depth", {23'd0, depth}, 32'd256);
        do_op("overflow_push", 1'b0, 1'b0, 16'hDEAD, 1'b1, 16'hBEEF, 9'd256);
        do_op("pop_after_full", 1'b0, 1'b1, 16'h0, 1'b0, {8'd127, ~8'd127}, 9'd254);

        // Reset during POP_HI: everything clears at once, no ack follows.
        e_req = 1'b1; e_pop = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_in_pop", {31'd0, stk_pop}, 32'd1);
        rst = 1'b1;
        e_req = 1'b0;
        #1;
        outs = {e_ack, i_ack, err, busy, stk_push, stk_pop, stk_in, 18'd0};
        check("midpop_ctrl_outs", outs, 32'd0);
        check("midpop_rdata", {16'd0, rdata}, 32'd0);
        check("midpop_depth", {23'd0, depth}, 32'd0);
        late_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (e_ack || i_ack) late_ack++;
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (e_ack || i_ack || busy) late_ack++;
        end
        check("midpop_no_ack", late_ack, 0);
        @(posedge clk); #1;
        do_op("pop_after_reset", 1'b0, 1'b1, 16'h0, 1'b1, 16'h0000, 9'd0);
        check("model_sp_vs_depth", {23'd0, sp}, {23'd0, depth});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
